// File: rtl/param_fifo.sv
// ---------------------------------------------------------------------------
// param_fifo
//   Single-clock first-word-fall-through FIFO. It is the common elastic buffer
//   between virtualisation shims and AXI-Stream/AXI-MM datapaths. Any depth
//   (not only powers of two), with an occupancy count, programmable
//   almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
//   Build option: define PARAM_FIFO_OUTREG_EN to drive dout from a dedicated
//   output register, so the memory read is registered and BRAM-inferable.
//   With the option the FIFO holds DEPTH+1 words, and a word pushed into an
//   empty FIFO reaches dout two cycles after its write edge. Without the
//   option the FIFO holds DEPTH words, dout is a combinational read of the
//   memory (LUTRAM) and the latency is one cycle.
//
// Ports
//   clk           rising-edge clock for every interface
//   rst           synchronous, active-high reset; it discards all contents
//   din, wr_en    write data and push request (ignored while full)
//   full          no space left
//   almost_full   count >= AF_THRESH
//   dout          head-of-FIFO data, valid while !empty
//   rd_en         pop request (ignored while empty)
//   empty         no data to read
//   almost_empty  count <= AE_THRESH
//   count         words currently held, including the output register
//   overflow      sticky: wr_en was seen while full
//   underflow     sticky: rd_en was seen while empty
// ---------------------------------------------------------------------------
module param_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 12,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int CNT_W      = $clog2(DEPTH + 2)   // derived; do not override
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

`ifdef PARAM_FIFO_OUTREG_EN
    localparam int CAPACITY = DEPTH + 1;
`else
    localparam int CAPACITY = DEPTH;
`endif

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;
    logic                  pop;

    // The pointers wrap explicitly, so a DEPTH that is not a power of two
    // never reaches the unused pointer codes.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // full and empty come from the state before the edge. A push is
    // therefore refused while full, even when a pop happens in the same cycle.
    assign push         = wr_en && !full;
    assign pop          = rd_en && !empty;
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments, so every
            // always_ff reads the values from before the edge and simulation
            // order cannot matter.
            if (wr_en && full)
                overflow <= 1'b1;
            if (rd_en && empty)
                underflow <= 1'b1;
        end
    end

`ifdef PARAM_FIFO_OUTREG_EN

    // The memory is a backing store behind a one-word output stage.
    // count = words in memory + out_valid.
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_W-1:0]      mem_cnt;
    logic                  load;

    // Refill the output stage when it is free or being popped this cycle,
    // as long as the memory has a word. This keeps pops back-to-back.
    assign load  = (mem_cnt != '0) && (!out_valid || pop);
    assign count = mem_cnt + CNT_W'(out_valid);
    assign full  = (count == FULL_CNT);
    assign empty = !out_valid;
    assign dout  = out_data;

    // NOTE: the storage array and its read register have no reset. The
    // occupancy state alone decides what is valid, and leaving out the reset
    // keeps the array inferable as RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
        if (load)
            out_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (load)
                rd_ptr <= ptr_inc(rd_ptr);

            if (load)
                out_valid <= 1'b1;
            else if (pop)
                out_valid <= 1'b0;

            case ({push, load})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

`else

    // dout is a combinational read at the head pointer (LUTRAM).
    logic [CNT_W-1:0] count_q;

    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign dout  = mem[rd_ptr];

    // NOTE: the storage array has no reset. The occupancy state alone decides
    // what is valid, and leaving out the reset keeps the array inferable as
    // RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_param_fifo.sv
// ---------------------------------------------------------------------------
// tb_param_fifo
//   Self-checking bench for param_fifo (DEPTH=12, AF_THRESH=10, AE_THRESH=2).
//   A queue-based reference model is compared against every output on every
//   cycle. Directed sequences (fill/drain, overflow and pointer wrap,
//   simultaneous push/pop, underflow, reset mid-operation) pin the model with
//   literal expectations. A randomized phase follows. The bench follows
//   PARAM_FIFO_OUTREG_EN, so it matches the build under test.
// ---------------------------------------------------------------------------
module tb_param_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int CNT_W = $clog2(DEPTH + 2);
`ifdef PARAM_FIFO_OUTREG_EN
    localparam bit OUTREG = 1'b1;
`else
    localparam bit OUTREG = 1'b0;
`endif
    localparam int CAP = OUTREG ? DEPTH + 1 : DEPTH;

    logic             clk;
    logic             rst;
    logic [DW-1:0]    din;
    logic             wr_en;
    logic             full;
    logic             almost_full;
    logic [DW-1:0]    dout;
    logic             rd_en;
    logic             empty;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    param_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .wr_en       (wr_en),
        .full        (full),
        .almost_full (almost_full),
        .dout        (dout),
        .rd_en       (rd_en),
        .empty       (empty),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // q holds every word stored in the FIFO, oldest first. vis tells whether
    // the head word is presented on dout.
    logic [DW-1:0] q[$];
    bit            vis   = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            live  = 1'b0;

    always @(posedge clk) begin : model
        bit m_push;
        bit m_pop;
        int mem_words;
        if (rst) begin
            q.delete();
            vis   = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            live  = 1'b1;
        end else begin
            m_push    = wr_en && (q.size() != CAP);
            m_pop     = rd_en && vis;
            mem_words = q.size() - int'(vis);
            if (wr_en && q.size() == CAP) m_ovf = 1'b1;
            if (rd_en && !vis)            m_unf = 1'b1;
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(din);
            if (OUTREG)
                // The output stage is valid after the edge if a stored word
                // could move into it, or if it held a word that was not popped.
                vis = (mem_words > 0) || (vis && !m_pop);
            else
                vis = (q.size() > 0);
        end
        #1;
        if (live) begin
            check("count",        count,        q.size());
            check("empty",        empty,        !vis);
            check("full",         full,         q.size() == CAP);
            check("almost_full",  almost_full,  q.size() >= AF);
            check("almost_empty", almost_empty, q.size() <= AE);
            check("overflow",     overflow,     m_ovf);
            check("underflow",    underflow,    m_unf);
            if (vis) check("dout", dout, q[0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit w, input logic [DW-1:0] d, input bit r);
        @(negedge clk);
        rst   = 1'b0;
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic fill(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) tick(1'b1, DW'(base + i), 1'b0);
    endtask

    // Pops n words and checks that they come out as base, base+1, ...
    task automatic drain_check(input string name, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            check({name, "_valid"}, empty, 1'b0);
            check({name, "_data"}, dout, DW'(base + i));
            tick(1'b0, '0, 1'b1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        reset_pulse();

        // Reset state
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);

        // Fill and drain
        for (int i = 1; i <= CAP; i++) begin
            tick(1'b1, DW'(i), 1'b0);
            if (i == 9)  check("af_below", almost_full, 0);
            if (i == 10) check("af_at_10", almost_full, 1);
            if (i == CAP - 1) check("not_full_yet", full, 0);
        end
        check("fill_full", full, 1);
        check("fill_count", count, CAP);
        drain_check("drain", CAP, 8'h01);
        check("drain_empty", empty, 1);
        check("drain_ae", almost_empty, 1);

        // Overflow, sticky flag, then pointer wrap
        fill(CAP, 8'h01);
        tick(1'b1, 8'hEE, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, CAP);
        for (int i = 0; i < 20; i++) tick(1'b0, '0, 1'b0);
        check("ovf_sticky", overflow, 1);
        drain_check("ovf_drain", CAP, 8'h01);
        fill(CAP, 8'h40);
        drain_check("wrap_drain", CAP, 8'h40);

        // Simultaneous push/pop at count 5
        reset_pulse();
        fill(5, 8'h01);
        for (int k = 0; k < 30; k++) begin
            check("pp_data", dout, DW'(1 + k));
            tick(1'b1, DW'(6 + k), 1'b1);
            check("pp_count", count, 5);
        end

        // Push and pop together while full: the pop wins and the push is refused
        reset_pulse();
        fill(CAP, 8'h80);
        tick(1'b1, 8'hEE, 1'b1);
        check("full_pp_count", count, CAP - 1);
        check("full_pp_ovf", overflow, 1);
        drain_check("full_pp_drain", CAP - 1, 8'h81);

        // Underflow
        reset_pulse();
        tick(1'b0, '0, 1'b1);
        check("unf_count", count, 0);
        check("unf_set", underflow, 1);
        tick(1'b1, 8'hA5, 1'b0);
        if (OUTREG) begin
            check("fwft_not_yet", empty, 1);
            tick(1'b0, '0, 1'b0);
        end
        check("fwft_valid", empty, 0);
        check("fwft_data", dout, 8'hA5);

        // Reset mid-operation
        fill(6, 8'h10);
        check("mid_count", count, 7);
        reset_pulse();
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_unf", underflow, 0);
        check("mid_rst_ovf", overflow, 0);
        tick(1'b1, 8'h3C, 1'b0);
        if (OUTREG) tick(1'b0, '0, 1'b0);
        check("mid_readback", dout, 8'h3C);

        // Randomized traffic, in phases that push the FIFO toward full,
        // toward empty, balanced, and busy.
        for (int c = 0; c < 3000; c++) begin
            int wp;
            int rp;
            case ((c / 250) % 4)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                2:       begin wp = 50; rp = 50; end
                default: begin wp = 95; rp = 95; end
            endcase
            if ($urandom_range(0, 399) == 0)
                reset_pulse();
            else
                tick($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp);
        end

        tick(1'b0, '0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Synchronous single-clock FIFO with first-word-fall-through (FWFT) output. It generalises the team's basic LUTRAM FIFO in five ways:
- arbitrary (non-power-of-2) depth
- occupancy count output
- programmable almost-full / almost-empty thresholds
- sticky overflow / underflow error flags
- optional output register for timing closure

Intended as the common elastic buffer between virtualisation shims and AXI-Stream/AXI-MM datapaths.

Parameters:
- DATA_WIDTH, 8, width of din/dout in bits (>=1)
- DEPTH, 12, number of storage words in the memory array (>=2, any integer)
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
- CNT_W, $clog2(DEPTH+2), derived, not to be overridden; width of count

Ports:
- clk  in  1  clock; all interfaces synchronous to rising edge
- rst  in  1  reset, synchronous, active-high
- din  in  DATA_WIDTH  write data
- wr_en  in  1  push request
- full  out  1  no space; pushes ignored
- almost_full  out  1  count >= AF_THRESH
- dout  out  DATA_WIDTH  head-of-FIFO data, valid when !empty
- rd_en  in  1  pop request
- empty  out  1  no data; pops ignored
- almost_empty  out  1  count <= AE_THRESH
- count  out  CNT_W  words currently held (including output register if present)
- overflow  out  1  sticky: wr_en seen while full
- underflow  out  1  sticky: rd_en seen while empty

Behaviour:
- Accept rules:
  - push accepted = wr_en && !full
  - pop accepted = rd_en && !empty
  - full/empty are evaluated on the pre-edge state, so a push is rejected when full even if a pop occurs in the same cycle.
- Pointers: rd_ptr and wr_ptr have width $clog2(DEPTH) and wrap explicitly from DEPTH-1 to 0. Power-of-2 overflow must not be relied on.
- count update each cycle:
  - push only: +1
  - pop only: -1
  - both: unchanged, both pointers advance
  - neither: hold
- Flag derivation:
  - full and empty are decoded from count.
  - almost_full and almost_empty are combinational compares on count.
- Memory: write-only at mem[wr_ptr] on an accepted push. No reset of array contents.
- dout without macro: combinational mem[rd_ptr] (LUTRAM inferable).
- Error flags:
  - overflow sets on any cycle with wr_en && full.
  - underflow sets on any cycle with rd_en && empty.
  - Both hold until rst.
- Reset values: count=0, pointers=0, empty=1, full=0, almost_empty=1 (AE_THRESH>=0), almost_full=0 (AF_THRESH>0), overflow=0, underflow=0, dout=don't care.
- Reset mid-operation discards all contents. Outputs return to reset values on the cycle after rst is sampled high.
- Latency without macro:
  - push at edge N -> empty=0 and dout valid after edge N (1 cycle)
  - pop at edge N -> next word on dout after edge N

Optional Feature:
Macro PARAM_FIFO_OUTREG_EN.

Defined: dout is driven from a dedicated output register (out_valid, out_data) so memory read is registered and BRAM-inferable.
- Total capacity: DEPTH+1 words.
- full: count == DEPTH+1.
- count includes out_valid.
- empty: !out_valid.
- Output register load: when (!out_valid || pop accepted) and the memory holds a word, out_data <= mem[rd_ptr] and rd_ptr advances.
- Fall-through: a push into a fully empty FIFO appears on dout 2 cycles after the write edge. empty deasserts at the same time as dout becomes valid.
- Back-to-back pops: must sustain one word per cycle with no bubbles while the memory is non-empty.
- Reset: out_valid=0.

Undefined: behaviour as in Behaviour above. Capacity is DEPTH and latency is 1 cycle.

Test Plan:
- Fill/drain, DEPTH=12, no macro:
  - Push 0x01..0x0C -> full=1 after 12th edge, count=12, almost_full=1 from count=10.
  - Pop 12 -> dout 0x01..0x0C in order, empty=1, almost_empty=1 at count<=2.
- Overflow and wrap:
  - 13th push while full -> data 0x0D never read out, overflow=1 and stays 1 through 20 further cycles.
  - Then drain and refill 12 -> pointers wrap past 11 -> 0 with correct ordering.
- Simultaneous push/pop:
  - Hold count=5 with wr_en=rd_en=1 for 30 cycles -> count stays 5, output sequence is continuous.
  - At full with both asserted -> pop accepted, push rejected, count=11, overflow=1.
- Underflow: rd_en=1 on empty reset FIFO -> count stays 0, dout ignored, underflow=1; push 0xA5 -> dout=0xA5 next cycle.
- Reset mid-operation: count=7, assert rst 1 cycle -> count=0, empty=1, overflow=underflow=0; next push 0x3C reads back 0x3C.
- PARAM_FIFO_OUTREG_EN, DEPTH=12:
  - 13 pushes accepted before full=1.
  - First word visible 2 cycles after write.
  - Continuous rd_en drains 13 words with no gap cycles.
